// File: rtl/bitops_alu_pkg.sv
// Shared opcodes, FSM states and helpers for the sequential bit-ops ALU.
// Optional feature macro: BITOPS_ALU_BITREV_EN (enables opcode 110).
package bitops_alu_pkg;

    localparam logic [2:0] OP_PARITY   = 3'd0;
    localparam logic [2:0] OP_POPCOUNT = 3'd1;
    localparam logic [2:0] OP_ROTR     = 3'd2;
    localparam logic [2:0] OP_ROTL     = 3'd3;
    localparam logic [2:0] OP_CLZ      = 3'd4;
    localparam logic [2:0] OP_CTZ      = 3'd5;
    localparam logic [2:0] OP_BITREV   = 3'd6;
    localparam logic [2:0] OP_RSVD     = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_OFF   = 1'b0,
        MODE_COUNT = 1'b1
    } chunk_mode_e;

    localparam int MAX_CHUNK = 1024;
    localparam int POP_W     = $clog2(MAX_CHUNK) + 1;

    function automatic logic [POP_W-1:0] chunk_popcount(
        input logic [MAX_CHUNK-1:0] v
    );
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_CHUNK; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_PARITY) || (op == OP_POPCOUNT) ||
               (op == OP_CLZ) || (op == OP_CTZ);
    endfunction

endpackage

// File: rtl/bitops_chunk_unit.sv
// Per-cycle slice evaluator: counts one CHUNK_WIDTH slice of the operand.
// Optional feature macro: BITOPS_ALU_BITREV_EN (not used in this file).
module bitops_chunk_unit
    import bitops_alu_pkg::*;
#(
    parameter int CHUNK_WIDTH = 64,
    localparam int CNT_W = $clog2(CHUNK_WIDTH) + 1
) (
    input  logic [CHUNK_WIDTH-1:0] chunk,
    input  chunk_mode_e            mode,
    output logic [CNT_W-1:0]       pop_cnt,
    output logic                   parity,
    output logic [CNT_W-1:0]       lz_cnt,
    output logic [CNT_W-1:0]       tz_cnt,
    output logic                   all_zero
);

    logic [CHUNK_WIDTH-1:0] data;
    logic [POP_W-1:0]       pop_full;

    // Isolate the slice when idle so the counting logic does not toggle
    always_comb begin
        data     = (mode == MODE_COUNT) ? chunk : '0;
        pop_full = chunk_popcount(MAX_CHUNK'(data));
        pop_cnt  = pop_full[CNT_W-1:0];
        parity   = ^data;
        all_zero = ~|data;
    end

    // Leading zeros: the highest set bit wins
    always_comb begin
        lz_cnt = CNT_W'(CHUNK_WIDTH);
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            if (data[i]) lz_cnt = CNT_W'(CHUNK_WIDTH - 1 - i);
        end
    end

    // Trailing zeros: the lowest set bit wins
    always_comb begin
        tz_cnt = CNT_W'(CHUNK_WIDTH);
        for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
            if (data[i]) tz_cnt = CNT_W'(i);
        end
    end

endmodule

// File: rtl/bitops_alu_seq.sv
// Handshaked bit-manipulation ALU; counting ops iterate one chunk per cycle.
// Optional feature macro: BITOPS_ALU_BITREV_EN (opcode 110 = bit reverse).
module bitops_alu_seq
    import bitops_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int CHUNK_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            opcode,
    input  logic [DATA_WIDTH-1:0] A_in,
    input  logic [DATA_WIDTH-1:0] B_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Alu_out,
    output logic                  illegal_op
);

    localparam int SW    = $clog2(DATA_WIDTH);
    localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int RES_W = SW + 1;
    localparam int CNT_W = $clog2(CHUNK_WIDTH) + 1;

    if ((DATA_WIDTH % CHUNK_WIDTH) != 0 ||
        (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 ||
        DATA_WIDTH < 8) begin : g_bad_cfg
        $error("bitops_alu_seq: bad DATA_WIDTH/CHUNK_WIDTH");
    end

    state_e                  state_q, state_d;
    logic [2:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [IDX_W-1:0]        idx_q, sel;
    logic [RES_W-1:0]        acc_q, acc_d;
    logic                    found_q, found_d;
    logic [DATA_WIDTH-1:0]   alu_q, single_res;
    logic                    ill_q, single_ill;
    logic [2*DATA_WIDTH-1:0] rotr_w, rotl_w;
    logic [SW-1:0]           shamt;
    logic [CHUNK_WIDTH-1:0]  chunk;
    chunk_mode_e             mode;
    logic [CNT_W-1:0]        pop_cnt, lz_cnt, tz_cnt;
    logic                    parity, all_zero;
    logic                    accept, last, unused_b;

    assign accept   = in_valid & in_ready;
    assign last     = (idx_q == IDX_W'(N - 1));
    assign shamt    = B_in[SW-1:0];
    assign unused_b = ^B_in[DATA_WIDTH-1:SW];
    assign mode     = (state_q == BUSY) ? MODE_COUNT : MODE_OFF;
    assign Alu_out    = alu_q;
    assign illegal_op = ill_q;

    bitops_chunk_unit #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_chunk (
        .chunk    (chunk),
        .mode     (mode),
        .pop_cnt  (pop_cnt),
        .parity   (parity),
        .lz_cnt   (lz_cnt),
        .tz_cnt   (tz_cnt),
        .all_zero (all_zero)
    );

    // Single-cycle results computed straight from the request
    always_comb begin
        rotr_w     = {A_in, A_in} >> shamt;
        rotl_w     = {A_in, A_in} << shamt;
        single_res = '0;
        single_ill = 1'b0;
        unique case (1'b1)
            opcode == OP_ROTR: single_res = rotr_w[DATA_WIDTH-1:0];
            opcode == OP_ROTL: single_res = rotl_w[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef BITOPS_ALU_BITREV_EN
            opcode == OP_BITREV: begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    single_res[i] = A_in[DATA_WIDTH-1-i];
                end
            end
`else
            opcode == OP_BITREV: single_ill = 1'b1;
`endif
            opcode == OP_RSVD: single_ill = 1'b1;
            default: single_ill = 1'b0;
        endcase
    end

    // CLZ walks chunks from the top, everything else from the bottom
    always_comb begin
        sel   = (op_q == OP_CLZ) ? IDX_W'(N - 1) - idx_q : idx_q;
        chunk = a_q[sel*CHUNK_WIDTH +: CHUNK_WIDTH];
    end

    // Fold this cycle's chunk into the running result
    always_comb begin
        acc_d   = acc_q;
        found_d = found_q;
        unique case (1'b1)
            op_q == OP_PARITY:   acc_d[0] = acc_q[0] ^ parity;
            op_q == OP_POPCOUNT: acc_d = acc_q + RES_W'(pop_cnt);
            op_q == OP_CLZ: begin
                if (!found_q) begin
                    acc_d   = acc_q + RES_W'(lz_cnt);
                    found_d = ~all_zero;
                end
            end
            op_q == OP_CTZ: begin
                if (!found_q) begin
                    acc_d   = acc_q + RES_W'(tz_cnt);
                    found_d = ~all_zero;
                end
            end
            default: acc_d = acc_q;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = is_iter_op(opcode) ? BUSY : DONE;
            BUSY: if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM handshake outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operand capture, chunk iteration and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_PARITY;
            a_q     <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            found_q <= 1'b0;
            alu_q   <= '0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= opcode;
            a_q     <= A_in;
            idx_q   <= '0;
            acc_q   <= '0;
            found_q <= 1'b0;
            if (!is_iter_op(opcode)) begin
                alu_q <= single_res;
                ill_q <= single_ill;
            end
        end else if (state_q == BUSY) begin
            idx_q   <= idx_q + 1'b1;
            acc_q   <= acc_d;
            found_q <= found_d;
            if (last) begin
                alu_q <= DATA_WIDTH'(acc_d);
                ill_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitops_alu_seq.sv
// Directed bench for bitops_alu_seq with a reference model and literal pins.
// Optional feature macro: BITOPS_ALU_BITREV_EN (changes expectation for 110).
module tb_bitops_alu_seq;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    opcode;
    logic [DW-1:0] A_in;
    logic [DW-1:0] B_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] Alu_out;
    logic          illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_res = '0;
    logic          exp_ill = 1'b0;

    bitops_alu_seq #(.DATA_WIDTH(DW), .CHUNK_WIDTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .A_in       (A_in),
        .B_in       (B_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Alu_out    (Alu_out),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op,
                                  input logic [DW-1:0] a,
                                  input int b,
                                  output logic [DW-1:0] r,
                                  output logic ill);
        int n;
        r   = '0;
        ill = 1'b0;
        case (op)
            3'd0: r = DW'($countones(a) % 2);
            3'd1: r = DW'($countones(a));
            3'd2: for (int i = 0; i < DW; i++) r[i] = a[(i + b) % DW];
            3'd3: for (int i = 0; i < DW; i++) r[(i + b) % DW] = a[i];
            3'd4: begin
                n = 0;
                while (n < DW && a[DW-1-n] == 1'b0) n++;
                r = DW'(n);
            end
            3'd5: begin
                n = 0;
                while (n < DW && a[n] == 1'b0) n++;
                r = DW'(n);
            end
`ifdef BITOPS_ALU_BITREV_EN
            3'd6: for (int i = 0; i < DW; i++) r[i] = a[DW-1-i];
`else
            3'd6: ill = 1'b1;
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    // Every cycle a result is presented it must match the model
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("model_alu", Alu_out, exp_res);
            check("model_ill", DW'(illegal_op), DW'(exp_ill));
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [DW-1:0] a,
                          input int b, input int hold, input bit early,
                          output logic [DW-1:0] res, output logic ill);
        int lat;
        int want_lat;
        bit got;
        want_lat = (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5)
                   ? 9 : 1;
        model(op, a, b, exp_res, exp_ill);
        in_valid = 1'b1;
        opcode   = op;
        A_in     = a;
        B_in     = DW'(b);
        check("accept_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        opcode    = 3'($urandom);
        A_in      = {16{$urandom}};
        B_in      = {16{$urandom}};
        out_ready = early;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
            check("busy_in_ready", DW'(in_ready), DW'(0));
        end
        check("latency", DW'(lat), DW'(want_lat));
        res = Alu_out;
        ill = illegal_op;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", DW'(out_valid), DW'(1));
            check("hold_data", Alu_out, res);
            check("hold_in_ready", DW'(in_ready), DW'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", DW'(out_valid), DW'(0));
        check("post_in_ready", DW'(in_ready), DW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] r;
        logic          il;
        logic [DW-1:0] v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 3'd0;
        A_in      = '0;
        B_in      = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", DW'(in_ready), DW'(1));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_alu", Alu_out, '0);
        check("rst_ill", DW'(illegal_op), DW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, DW'(8'b10101101), 0, 0, 1'b0, r, il);
        check("parity_ad", r, DW'(1));
        check("parity_ad_ill", DW'(il), DW'(0));
        run_op(3'd0, DW'(8'b10101100), 0, 0, 1'b0, r, il);
        check("parity_ac", r, DW'(0));

        run_op(3'd1, '1, 0, 0, 1'b0, r, il);
        check("pop_ones", r, DW'(512));
        run_op(3'd1, DW'(8'b11101101), 0, 0, 1'b0, r, il);
        check("pop_ed", r, DW'(6));

        v = '0;
        v[300] = 1'b1;
        run_op(3'd4, v, 0, 5, 1'b0, r, il);
        check("clz_300", r, DW'(211));
        run_op(3'd5, v, 0, 0, 1'b1, r, il);
        check("ctz_300", r, DW'(300));
        run_op(3'd4, '0, 0, 0, 1'b0, r, il);
        check("clz_zero", r, DW'(512));
        run_op(3'd5, '0, 0, 0, 1'b0, r, il);
        check("ctz_zero", r, DW'(512));

        run_op(3'd2, DW'(8'b10101101), 3, 0, 1'b0, r, il);
        check("rotr_hi", DW'(r[511:509]), DW'(3'b101));
        check("rotr_lo", DW'(r[4:0]), DW'(5'b10101));
        v = '0;
        v[511:504] = 8'b10101101;
        run_op(3'd3, v, 3, 5, 1'b0, r, il);
        check("rotl_hi", DW'(r[511:504]), DW'(8'b01101000));
        check("rotl_lo", DW'(r[2:0]), DW'(3'b101));
        run_op(3'd2, {16{32'hdeadbeef}}, 0, 0, 1'b0, r, il);
        check("rotr_zero", r, {16{32'hdeadbeef}});
        run_op(3'd3, DW'(64'h1), 511, 0, 1'b0, r, il);
        check("rotl_511", r, {1'b1, 511'b0});

        run_op(3'd7, '1, 0, 0, 1'b0, r, il);
        check("rsvd_alu", r, '0);
        check("rsvd_ill", DW'(il), DW'(1));
        run_op(3'd6, DW'(8'hf0), 0, 0, 1'b0, r, il);
`ifdef BITOPS_ALU_BITREV_EN
        check("bitrev_alu", DW'(r[511:504]), DW'(8'h0f));
        check("bitrev_ill", DW'(il), DW'(0));
`else
        check("op110_alu", r, '0);
        check("op110_ill", DW'(il), DW'(1));
`endif
        run_op(3'd1, DW'(8'h0f), 0, 0, 1'b0, r, il);
        check("pop_after_ill", r, DW'(4));
        check("pop_after_ill_flag", DW'(il), DW'(0));

        in_valid = 1'b1;
        opcode   = 3'd1;
        A_in     = '1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", DW'(out_valid), DW'(0));
        check("abort_in_ready", DW'(in_ready), DW'(1));
        check("abort_alu", Alu_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3'd1, DW'(8'b11101101), 0, 0, 1'b0, r, il);
        check("pop_after_reset", r, DW'(6));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
